// File: rtl/if_id_fetch_reg.sv
// Fetch control and IF/ID pipeline register.
// Owns the architectural PC and issues one instruction-memory request at a
// time. Each returned word is paired with its fetch address. Words that
// arrive while ID is stalled are parked in a small skid FIFO, and one
// {inst, pc, pc+4} bundle is presented to ID per cycle.
module if_id_fetch_reg #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] if_inst_addr,
    input  logic [31:0] if_pc4,
    output logic [31:0] pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W:0]   DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] FULL_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    typedef enum logic {BOOT, FETCH} state_t;

    // Next-sequential address, wrapping mod 2^32.
    function automatic logic [31:0] add4(input logic [31:0] a);
        return a + 32'd4;
    endfunction

    state_t             state;
    logic [CNT_W-1:0]   count;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic               inflight_p1;
    logic [31:0]        tag_p1;
    logic [31:0]        fifo_inst [FIFO_DEPTH];
    logic [31:0]        fifo_pc   [FIFO_DEPTH];

    logic [CNT_W:0]     used;
    logic               issue;
    logic               rsp_vld;
    logic               fifo_empty;
    logic               fifo_full;
    logic               fifo_push;
    logic               fifo_pop;

    // Credit check: buffered words plus the outstanding one must leave room,
    // so a stalled ID can never overflow the skid FIFO.
    assign used       = {1'b0, count} + {{CNT_W{1'b0}}, inflight_p1};
    assign imem_req   = (state == FETCH) && (used < DEPTH_C);
    assign imem_addr  = if_inst_addr;
    assign issue      = imem_req & imem_gnt;

    // A response only counts if we asked for it, and a redirect kills it.
    assign rsp_vld    = imem_rvalid & inflight_p1 & ~flush;
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FULL_C);
    assign fifo_pop   = ~flush & ~stall & ~fifo_empty;
    // With an empty FIFO and ID free, the response bypasses straight to ID.
    assign fifo_push  = rsp_vld & (stall | ~fifo_empty);

    // Control state: FSM, PC, outstanding-request flag and FIFO bookkeeping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            inflight_p1 <= 1'b0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            if (state == BOOT)
                state <= FETCH;

            if (issue)
                pc <= if_pc4;

            if (issue)
                inflight_p1 <= 1'b1;
            else if (imem_rvalid)
                inflight_p1 <= 1'b0;

            if (flush) begin
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (fifo_push)
                    wr_ptr <= wr_ptr + PTR_ONE;
                if (fifo_pop)
                    rd_ptr <= rd_ptr + PTR_ONE;
                if (fifo_push && !fifo_pop)
                    count <= count + CNT_ONE;
                else if (fifo_pop && !fifo_push)
                    count <= count - CNT_ONE;
            end
        end
    end

    // Fetch address of the outstanding request, paired with its data later.
    always_ff @(posedge clk) begin
        if (issue)
            tag_p1 <= if_inst_addr;
    end

    // Skid FIFO storage; validity is tracked by count, so no reset needed.
    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_inst[wr_ptr] <= imem_rdata;
            fifo_pc[wr_ptr]   <= tag_p1;
        end
    end

    // ID bundle: flush beats stall; otherwise FIFO head, then bypass, then bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            id_valid <= 1'b0;
            id_inst  <= NOP_INST;
            id_pc    <= 32'h0;
            id_pc4   <= 32'h0;
        end else if (flush) begin
            id_valid <= 1'b0;
            id_inst  <= NOP_INST;
        end else if (!stall) begin
            if (!fifo_empty) begin
                id_valid <= 1'b1;
                id_inst  <= fifo_inst[rd_ptr];
                id_pc    <= fifo_pc[rd_ptr];
                id_pc4   <= add4(fifo_pc[rd_ptr]);
            end else if (rsp_vld) begin
                id_valid <= 1'b1;
                id_inst  <= imem_rdata;
                id_pc    <= tag_p1;
                id_pc4   <= add4(tag_p1);
            end else begin
                id_valid <= 1'b0;
                id_inst  <= NOP_INST;
            end
        end
    end

    // The credit rule makes a push into a full FIFO impossible.
    no_overflow: assert property (@(posedge clk) disable iff (!reset)
                                  !(fifo_push && fifo_full));

endmodule

// File: tb/tb_if_id_fetch_reg.sv
`timescale 1ns/1ps
module tb_if_id_fetch_reg;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam int          DEPTH    = 2;

    logic        clk, reset, stall, flush;
    logic [31:0] if_inst_addr, if_pc4, pc, imem_addr, imem_rdata;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic        id_valid;
    logic [31:0] id_inst, id_pc, id_pc4;

    if_id_fetch_reg #(
        .RESET_PC  (RESET_PC),
        .NOP_INST  (NOP),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .flush       (flush),
        .if_inst_addr(if_inst_addr),
        .if_pc4      (if_pc4),
        .pc          (pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .id_valid    (id_valid),
        .id_inst     (id_inst),
        .id_pc       (id_pc),
        .id_pc4      (id_pc4)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Accepted-but-not-yet-delivered words, oldest first: {inst, pc}.
    logic [63:0] q[$];

    // Behavioural model of the fetch side.
    logic [31:0] pc_m, tag_m, mem_data, redir_tgt;
    logic        mem_pend, inflight_m, booted, redir_pend, rel_pend;
    int          flush_cnt;

    // Stimulus flags of the cycle ending at the next rising edge.
    logic drv_stall, drv_flush;
    logic last_stall, last_flush;

    // Expected ID bundle.
    logic        exp_v;
    logic [31:0] exp_i, exp_pc, exp_pc4;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        last_stall <= drv_stall;
        last_flush <= drv_flush;
    end

    // Monitor: each edge ID either takes the oldest undelivered word, shows a
    // bubble, holds under stall, or is cleared by a flush.
    always @(negedge clk) begin
        logic [63:0] b;
        if (!reset) begin
            exp_v   = 1'b0;
            exp_i   = NOP;
            exp_pc  = 32'h0;
            exp_pc4 = 32'h0;
        end else begin
            if (last_flush) begin
                exp_v = 1'b0;
                exp_i = NOP;
            end else if (!last_stall) begin
                if (q.size() > 0) begin
                    b       = q.pop_front();
                    exp_v   = 1'b1;
                    exp_i   = b[63:32];
                    exp_pc  = b[31:0];
                    exp_pc4 = b[31:0] + 32'd4;
                end else begin
                    exp_v = 1'b0;
                    exp_i = NOP;
                end
            end
            chk("id_valid", {31'b0, id_valid}, {31'b0, exp_v});
            chk("id_inst", id_inst, exp_i);
            chk("id_pc", id_pc, exp_pc);
            chk("id_pc4", id_pc4, exp_pc4);
        end
    end

    // One clock of stimulus plus the fetch-side checks for that cycle.
    task automatic cycle(input logic st, input logic fl, input logic gn, input logic spur);
        logic [31:0] tmp;
        logic        req_m, issue, rsp_ok;
        @(negedge clk);
        #2;
        if (rel_pend) begin
            reset    = 1'b1;
            rel_pend = 1'b0;
        end
        stall       = st;
        flush       = fl;
        imem_gnt    = gn;
        drv_stall   = st;
        drv_flush   = fl;
        imem_rvalid = mem_pend | spur;
        imem_rdata  = mem_pend ? mem_data : $urandom;
        if (fl) begin
            tmp = $urandom;
            if (flush_cnt == 0)           redir_tgt = 32'h0000_0100;
            else if (tmp[3:0] < 4'd4)     redir_tgt = 32'hFFFF_FFF8;
            else                          redir_tgt = tmp & 32'hFFFF_FFFC;
            redir_pend = 1'b1;
            flush_cnt++;
        end
        if_inst_addr = redir_pend ? redir_tgt : pc_m;
        if_pc4       = if_inst_addr + 32'd4;
        #1;
        req_m = booted && ((q.size() + (inflight_m ? 1 : 0)) < DEPTH);
        chk("imem_req", {31'b0, imem_req}, {31'b0, req_m});
        chk("pc", pc, pc_m);
        chk("imem_addr", imem_addr, if_inst_addr);
        rsp_ok = imem_rvalid && inflight_m && !fl;
        if (fl)          q.delete();
        else if (rsp_ok) q.push_back({imem_rdata, tag_m});
        issue    = req_m && gn;
        mem_pend = issue;
        if (issue) begin
            mem_data   = $urandom;
            tag_m      = if_inst_addr;
            pc_m       = if_inst_addr + 32'd4;
            redir_pend = 1'b0;
        end
        inflight_m = issue;
        booted     = 1'b1;
    endtask

    task automatic model_reset();
        q.delete();
        pc_m       = RESET_PC;
        inflight_m = 1'b0;
        mem_pend   = 1'b0;
        booted     = 1'b0;
        redir_pend = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_pc"}, pc, RESET_PC);
        chk({tag, "_req"}, {31'b0, imem_req}, 32'h0);
        chk({tag, "_id_valid"}, {31'b0, id_valid}, 32'h0);
        chk({tag, "_id_inst"}, id_inst, NOP);
        chk({tag, "_id_pc"}, id_pc, 32'h0);
        chk({tag, "_id_pc4"}, id_pc4, 32'h0);
    endtask

    initial begin
        logic [31:0] r;
        reset = 1'b0; stall = 1'b0; flush = 1'b0; imem_gnt = 1'b0;
        imem_rvalid = 1'b0; imem_rdata = 32'h0;
        if_inst_addr = 32'h0; if_pc4 = 32'h4;
        drv_stall = 1'b0; drv_flush = 1'b0;
        tag_m = 32'h0; mem_data = 32'h0; redir_tgt = 32'h0;
        flush_cnt = 0; rel_pend = 1'b0;
        model_reset();

        repeat (2) @(negedge clk);
        #2;
        chk_reset_outputs("rst");

        // Straight-line fetch from reset.
        rel_pend = 1'b1;
        repeat (30) cycle(1'b0, 1'b0, 1'b1, 1'b0);
        // Stall long enough to fill the FIFO, then flush while still stalled.
        repeat (4) cycle(1'b1, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        repeat (10) cycle(1'b0, 1'b0, 1'b1, 1'b0);
        // Grant withheld for a few cycles.
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (10) cycle(1'b0, 1'b0, 1'b1, 1'b0);
        // Plain redirect with a response arriving.
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        repeat (10) cycle(1'b0, 1'b0, 1'b1, 1'b0);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            r = $urandom;
            cycle(r[3:0] < 4'd5, r[11:8] == 4'd0, r[17:16] != 2'b00, 1'b0);
        end

        // Asynchronous reset between edges, then a stray rvalid after release.
        #2;
        reset = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        model_reset();
        rel_pend = 1'b1;
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 150; i++) begin
            r = $urandom;
            cycle(r[3:0] < 4'd4, r[11:8] == 4'd0, r[17:16] != 2'b00, 1'b0);
        end

        // Drain without new requests; everything accepted must be delivered.
        repeat (8) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        chk("drain_empty", q.size(), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_id_fetch_reg.md
Name: if_id_fetch_reg

Overview:
Fetch-control and IF/ID pipeline register that sits directly downstream of the IF stage. It holds the architectural PC that feeds the IF stage's pc input and issues instruction-memory requests at the IF stage's selected fetch address. It pairs each returned instruction with its PC. A skid FIFO absorbs returned instructions while ID is stalled, and the block presents one {inst, pc, pc+4} bundle per cycle to the ID stage, with stall and flush support.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded at reset.
NOP_INST, 32'h0000_0013, instruction presented to ID when id_valid=0 (addi x0,x0,0).
FIFO_DEPTH, 2, skid FIFO entries; legal values are 2 and 4.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
stall  input  1  hazard-unit stall; holds the ID outputs.
flush  input  1  branch/jump redirect taken; kills younger instructions.
if_inst_addr  input  32  fetch address selected by the IF stage this cycle.
if_pc4  input  32  if_inst_addr+4 from the IF stage.
pc  output  32  registered PC, fed back to the IF stage.
imem_req  output  1  instruction-memory request.
imem_addr  output  32  request address, equal to if_inst_addr.
imem_gnt  input  1  memory accepts the request this cycle.
imem_rvalid  input  1  read data valid; asserted exactly 1 cycle after an accepted request.
imem_rdata  input  32  instruction word.
id_valid  output  1  ID bundle valid.
id_inst  output  32  instruction to ID.
id_pc  output  32  PC of id_inst.
id_pc4  output  32  id_pc+4.

Behaviour:
- Reset (async, reset=0):
  - pc=RESET_PC, imem_req=0, id_valid=0, id_inst=NOP_INST, id_pc=0, id_pc4=0.
  - FIFO empty (count=0), inflight=0, state=BOOT.
- FSM:
  - BOOT: imem_req=0. Unconditionally goes to FETCH on the next clk.
  - FETCH: operating state. Leaves FETCH only through reset.
- Request generation:
  - In FETCH, imem_req = (count + inflight < FIFO_DEPTH).
  - imem_addr is combinational from if_inst_addr.
- Issue:
  - Issue occurs when imem_req & imem_gnt.
  - On issue: pc<=if_pc4, inflight<=1, and if_inst_addr is captured into the in-flight tag.
  - On no issue: pc holds, and inflight<=0 once its response has returned.
  - Only one request is outstanding at a time (fixed 1-cycle latency).
- Response:
  - Valid when imem_rvalid & inflight, except a response arriving in a flush cycle is discarded.
  - An imem_rvalid with inflight=0 is ignored.
- ID update, when flush=0 and stall=0, in priority order:
  - FIFO non-empty: pop the head into id_*, id_valid=1. A valid response in the same cycle is pushed behind it.
  - Else, valid response present: bypass it into id_* (id_pc=tag, id_pc4=tag+4), id_valid=1.
  - Else: id_valid=0, id_inst=NOP_INST, id_pc and id_pc4 hold.
- ID update, when stall=1 and flush=0:
  - id_* holds.
  - A valid response is pushed into the FIFO.
  - The credit rule guarantees no overflow; pushing to a full FIFO is an assertion failure.
- Flush (overrides stall):
  - FIFO cleared (count=0), id_valid=0, id_inst=NOP_INST.
  - The response arriving in the flush cycle is dropped.
  - A request issued in the flush cycle (at the redirect target supplied by IF) is kept, and its response is accepted the following cycle.
- Arithmetic: pc4 = pc+4 is computed mod 2^32 (0xFFFF_FFFC+4 = 0).
- FIFO pointers wrap mod FIFO_DEPTH. count is held in log2(FIFO_DEPTH)+1 bits.
- Reset mid-operation: all state returns immediately to reset values, and any in-flight response is ignored because inflight=0.

Test Plan:
1. Reset release, RESET_PC=0, imem_gnt=1 always, memory returns addr-derived words, if_pc4=if_inst_addr+4 → imem_req is 0 in the BOOT cycle. id_pc then shows 0x0, 0x4, 0x8 on consecutive cycles with id_valid=1; the first valid bundle appears 3 cycles after reset release.
2. Same stream, stall=1 for 4 cycles starting when id_pc=0x4 → id_* holds 0x4, FIFO fills to 2, imem_req=0 while full. After stall drops, id_pc shows 0x8, 0xC, 0x10 with no gap or duplicate.
3. Flush while the IF stage supplies target 0x100 and a response for 0xC is arriving → 0xC is dropped, id_valid=0 and id_inst=0x13 for that cycle, then id_pc=0x100, id_pc4=0x104.
4. Flush and stall together with FIFO count=2 → FIFO is cleared, id_valid=0, and no stale PC appears afterwards.
5. imem_gnt=0 for 3 cycles at addr 0x20 → pc holds, imem_req stays 1, and 0x20 is delivered once after grant.
6. Async reset asserted mid-stream with inflight=1 and the FIFO holding 1 entry → outputs return to reset values with no clock edge, and the late rvalid is ignored.
